// File: rtl/mem_loader.sv
// Stream-to-RAM loader: writes a valid/ready byte stream to consecutive RAM
// addresses, reads the region back, and compares modular checksums.
module mem_loader #(
    parameter int unsigned WORDSIZE  = 8,
    parameter int unsigned WORDCOUNT = 512,
    parameter int unsigned ADDRSIZE  = 9
) (
    input  logic                i_clock,
    input  logic                i_resetn,
    input  logic                i_start,
    input  logic [ADDRSIZE-1:0] i_base,
    input  logic [ADDRSIZE:0]   i_count,
    input  logic                i_in_valid,
    input  logic [WORDSIZE-1:0] i_in_data,
    input  logic                i_in_last,
    output logic                o_in_ready,
    output logic [ADDRSIZE-1:0] o_ram_addr,
    output logic                o_ram_wen,
    output logic [WORDSIZE-1:0] o_ram_wdat,
    output logic                o_ram_ren,
    input  logic [WORDSIZE-1:0] i_ram_rdat,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_ok,
    output logic [ADDRSIZE:0]   o_loaded
);

    localparam int unsigned   CW          = ADDRSIZE + 1;
    localparam logic [CW-1:0] WORDCOUNT_C = CW'(WORDCOUNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDRSIZE-1:0] r_wptr;
    logic [ADDRSIZE-1:0] w_wptr_next;
    logic [ADDRSIZE-1:0] r_rptr;
    logic [ADDRSIZE-1:0] w_rptr_next;
    logic [ADDRSIZE-1:0] r_ram_addr;
    logic [ADDRSIZE-1:0] w_ram_addr_next;

    // r_rem counts beats still allowed in LOAD, then reads still owed in VERIFY
    logic [CW-1:0]       r_rem;
    logic [CW-1:0]       w_rem_next;
    logic [CW-1:0]       r_loaded;
    logic [CW-1:0]       w_loaded_next;

    logic [WORDSIZE-1:0] r_wsum;
    logic [WORDSIZE-1:0] w_wsum_next;
    logic [WORDSIZE-1:0] r_rsum;
    logic [WORDSIZE-1:0] w_rsum_next;
    logic [WORDSIZE-1:0] r_ram_wdat;
    logic [WORDSIZE-1:0] w_ram_wdat_next;

    logic                r_in_ready;
    logic                w_in_ready_next;
    logic                r_ram_wen;
    logic                w_ram_wen_next;
    logic                r_ram_ren;
    logic                w_ram_ren_next;
    logic                r_busy;
    logic                w_busy_next;
    logic                r_done;
    logic                w_done_next;
    logic                r_ok;
    logic                w_ok_next;

    logic [CW-1:0]       w_count_clamp;
    logic                w_xfer;
    logic [WORDSIZE-1:0] w_rsum_acc;

    // Address increment modulo the RAM depth
    function automatic logic [ADDRSIZE-1:0] addr_inc(input logic [ADDRSIZE-1:0] a);
        logic [ADDRSIZE-1:0] res;
        if ({1'b0, a} == (WORDCOUNT_C - CW'(1))) begin
            res = '0;
        end else begin
            res = a + ADDRSIZE'(1);
        end
        return res;
    endfunction

    // Clamp the requested length to the RAM depth
    assign w_count_clamp = (i_count > WORDCOUNT_C) ? WORDCOUNT_C : i_count;

    // A beat moves when the registered ready meets a valid beat
    assign w_xfer = r_in_ready && i_in_valid;

    // Read data for the address driven this cycle is folded in at the closing edge
    assign w_rsum_acc = r_ram_ren ? (r_rsum + i_ram_rdat) : r_rsum;

    // Next-state and next-output logic
    always_comb begin
        w_state_next    = r_state;
        w_wptr_next     = r_wptr;
        w_rptr_next     = r_rptr;
        w_ram_addr_next = r_ram_addr;
        w_rem_next      = r_rem;
        w_loaded_next   = r_loaded;
        w_wsum_next     = r_wsum;
        w_rsum_next     = w_rsum_acc;
        w_ram_wdat_next = r_ram_wdat;
        w_ram_wen_next  = 1'b0;
        w_ram_ren_next  = 1'b0;
        w_done_next     = 1'b0;
        w_ok_next       = r_ok;
        w_busy_next     = r_done ? 1'b0 : r_busy;

        case (r_state)
            S_IDLE: begin
                if (i_start && !r_busy) begin
                    w_wptr_next   = i_base;
                    w_rptr_next   = i_base;
                    w_rem_next    = w_count_clamp;
                    w_loaded_next = '0;
                    w_wsum_next   = '0;
                    w_rsum_next   = '0;
                    w_ok_next     = 1'b0;
                    w_busy_next   = 1'b1;
                    w_state_next  = (w_count_clamp == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_ram_wen_next  = 1'b1;
                    w_ram_addr_next = r_wptr;
                    w_ram_wdat_next = i_in_data;
                    w_wptr_next     = addr_inc(r_wptr);
                    w_wsum_next     = r_wsum + i_in_data;
                    w_loaded_next   = r_loaded + CW'(1);
                    w_rem_next      = r_rem - CW'(1);
                    if (i_in_last || (r_rem == CW'(1))) begin
                        // Reuse the counter for the readback length
                        w_rem_next   = r_loaded + CW'(1);
                        w_state_next = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                w_ram_ren_next  = 1'b1;
                w_ram_addr_next = r_rptr;
                w_rptr_next     = addr_inc(r_rptr);
                w_rem_next      = r_rem - CW'(1);
                if (r_rem == CW'(1)) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                w_done_next  = 1'b1;
                w_ok_next    = (r_wsum == w_rsum_acc);
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_in_ready_next = (w_state_next == S_LOAD) && (w_rem_next != '0);
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_addr <= '0;
            r_rem      <= '0;
            r_loaded   <= '0;
            r_wsum     <= '0;
            r_rsum     <= '0;
            r_ram_wdat <= '0;
            r_in_ready <= 1'b0;
            r_ram_wen  <= 1'b0;
            r_ram_ren  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
        end else begin
            r_wptr     <= w_wptr_next;
            r_rptr     <= w_rptr_next;
            r_ram_addr <= w_ram_addr_next;
            r_rem      <= w_rem_next;
            r_loaded   <= w_loaded_next;
            r_wsum     <= w_wsum_next;
            r_rsum     <= w_rsum_next;
            r_ram_wdat <= w_ram_wdat_next;
            r_in_ready <= w_in_ready_next;
            r_ram_wen  <= w_ram_wen_next;
            r_ram_ren  <= w_ram_ren_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_ok       <= w_ok_next;
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_wen  = r_ram_wen;
    assign o_ram_wdat = r_ram_wdat;
    assign o_ram_ren  = r_ram_ren;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_ok       = r_ok;
    assign o_loaded   = r_loaded;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a falling-edge RAM model.
module tb_mem_loader;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       start    = 1'b0;
    logic [8:0] base     = '0;
    logic [9:0] count    = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = '0;
    logic       in_last  = 1'b0;
    logic       in_ready;
    logic [8:0] ram_addr;
    logic       ram_wen;
    logic [7:0] ram_wdat;
    logic       ram_ren;
    logic [7:0] ram_rdat = '0;
    logic       busy;
    logic       done;
    logic       ok;
    logic [9:0] loaded;

    always #5 clk = ~clk;

    mem_loader dut (
        .i_clock    (clk),
        .i_resetn   (resetn),
        .i_start    (start),
        .i_base     (base),
        .i_count    (count),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .i_in_last  (in_last),
        .o_in_ready (in_ready),
        .o_ram_addr (ram_addr),
        .o_ram_wen  (ram_wen),
        .o_ram_wdat (ram_wdat),
        .o_ram_ren  (ram_ren),
        .i_ram_rdat (ram_rdat),
        .o_busy     (busy),
        .o_done     (done),
        .o_ok       (ok),
        .o_loaded   (loaded)
    );

    logic [7:0] mem [0:511];
    logic [8:0] wlog_a [$];
    logic [7:0] wlog_d [$];
    logic [8:0] rlog_a [$];
    int         busy_cnt    = 0;
    int         rdy_cnt     = 0;
    int         done_cnt    = 0;
    int         cyc         = 0;
    int         done_cyc    = 0;
    logic       done_ok     = 1'b0;
    logic [9:0] done_loaded = '0;
    logic       corrupt     = 1'b0;
    logic [8:0] corrupt_addr = 9'h012;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model (falling-edge access) plus activity log
    always @(negedge clk) begin
        if (ram_wen) begin
            mem[ram_addr] <= ram_wdat;
            wlog_a.push_back(ram_addr);
            wlog_d.push_back(ram_wdat);
        end
        if (ram_ren) begin
            ram_rdat <= (corrupt && ram_addr == corrupt_addr) ? 8'h00 : mem[ram_addr];
            rlog_a.push_back(ram_addr);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (in_ready) rdy_cnt <= rdy_cnt + 1;
        if (done) begin
            done_cnt    <= done_cnt + 1;
            done_cyc    <= cyc;
            done_ok     <= ok;
            done_loaded <= loaded;
        end
    end

    int         n_chk  = 0;
    int         n_fail = 0;
    int         t0, s_busy, s_rdy, s_done, s_w, s_r, n_xfer;
    logic [7:0] beats [0:7];

    task automatic snap();
        s_busy = busy_cnt;
        s_rdy  = rdy_cnt;
        s_done = done_cnt;
        s_w    = wlog_a.size();
        s_r    = rlog_a.size();
    endtask

    // Pulse start; returns #1 into the first cycle after acceptance
    task automatic do_start(input logic [8:0] b, input logic [9:0] c);
        snap();
        start = 1'b1;
        base  = b;
        count = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic drive(input int ncyc, input bit gap, input int nbeats, input int last_idx);
        int  idx;
        bit  v;
        logic rdy;
        idx = 0;
        for (int j = 1; j <= ncyc; j++) begin
            v        = (gap ? (j % 2 == 1) : 1'b1) && (idx < nbeats);
            in_valid = v;
            in_data  = v ? beats[idx] : 8'h00;
            in_last  = v && (idx == last_idx);
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (v && rdy) idx++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_xfer   = idx;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            if (done_cnt != s_done) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [8:0] b, input logic [9:0] c, input int ncyc,
                            input bit gap, input int nbeats, input int last_idx);
        do_start(b, c);
        drive(ncyc, gap, nbeats, last_idx);
        wait_done();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({in_ready, ram_wen, ram_ren, busy, done, ok} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000", {in_ready, ram_wen, ram_ren, busy, done, ok});
        end
        n_chk++;
        if (ram_addr !== 9'h000) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 000", ram_addr);
        end
        n_chk++;
        if (ram_wdat !== 8'h00) begin
            n_fail++; $display("FAIL reset_wdat: got %h expected 00", ram_wdat);
        end
        n_chk++;
        if (loaded !== 10'd0) begin
            n_fail++; $display("FAIL reset_loaded: got %0d expected 0", loaded);
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load(9'h010, 10'd4, 4, 1'b0, 4, -1);
        n_chk++;
        if (done_cnt - s_done !== 1) begin
            n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - s_done);
        end
        n_chk++;
        if (done_cyc - t0 + 1 !== 10) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected 10", done_cyc - t0 + 1);
        end
        n_chk++;
        if (busy_cnt - s_busy !== 10) begin
            n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 10", busy_cnt - s_busy);
        end
        n_chk++;
        if (done_ok !== 1'b1 || done_loaded !== 10'd4) begin
            n_fail++; $display("FAIL basic_result: got ok=%b loaded=%0d expected ok=1 loaded=4", done_ok, done_loaded);
        end
        n_chk++;
        if (wlog_a.size() - s_w !== 4 || rlog_a.size() - s_r !== 4) begin
            n_fail++; $display("FAIL basic_access_counts: got w=%0d r=%0d expected w=4 r=4", wlog_a.size() - s_w, rlog_a.size() - s_r);
        end
        for (int i = 0; i < 4; i++) begin
            logic [8:0] ea;
            ea = 9'h010 + 9'(i);
            n_chk++;
            if (wlog_a[s_w + i] !== ea || wlog_d[s_w + i] !== beats[i] || rlog_a[s_r + i] !== ea) begin
                n_fail++;
                $display("FAIL basic_access[%0d]: got waddr=%h wdat=%h raddr=%h expected %h %h %h",
                         i, wlog_a[s_w + i], wlog_d[s_w + i], rlog_a[s_r + i], ea, beats[i], ea);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (ok !== 1'b1 || loaded !== 10'd4 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_hold: got ok=%b loaded=%0d busy=%b expected 1 4 0", ok, loaded, busy);
        end
    endtask

    task automatic test_gapped();
        beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load(9'h010, 10'd4, 7, 1'b1, 4, -1);
        n_chk++;
        if (done_cyc - t0 + 1 !== 13 || done_cnt - s_done !== 1) begin
            n_fail++; $display("FAIL gapped_latency: got %0d (pulses %0d) expected 13 (1)", done_cyc - t0 + 1, done_cnt - s_done);
        end
        n_chk++;
        if (rdy_cnt - s_rdy !== 7) begin
            n_fail++; $display("FAIL gapped_ready_cycles: got %0d expected 7", rdy_cnt - s_rdy);
        end
        n_chk++;
        if (wlog_a.size() - s_w !== 4) begin
            n_fail++; $display("FAIL gapped_writes: got %0d expected 4", wlog_a.size() - s_w);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (mem[9'h010 + 9'(i)] !== beats[i] || wlog_d[s_w + i] !== beats[i]) begin
                n_fail++; $display("FAIL gapped_ram[%0d]: got %h expected %h", i, mem[9'h010 + 9'(i)], beats[i]);
            end
        end
        n_chk++;
        if (done_ok !== 1'b1 || done_loaded !== 10'd4) begin
            n_fail++; $display("FAIL gapped_result: got ok=%b loaded=%0d expected 1 4", done_ok, done_loaded);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] exp_a [0:3];
        exp_a = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        beats = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load(9'h1FE, 10'd4, 4, 1'b0, 4, -1);
        n_chk++;
        if (wlog_a.size() - s_w !== 4 || rlog_a.size() - s_r !== 4) begin
            n_fail++; $display("FAIL wrap_access_counts: got w=%0d r=%0d expected 4 4", wlog_a.size() - s_w, rlog_a.size() - s_r);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (wlog_a[s_w + i] !== exp_a[i] || rlog_a[s_r + i] !== exp_a[i] || wlog_d[s_w + i] !== beats[i]) begin
                n_fail++;
                $display("FAIL wrap_access[%0d]: got waddr=%h raddr=%h wdat=%h expected %h %h %h",
                         i, wlog_a[s_w + i], rlog_a[s_r + i], wlog_d[s_w + i], exp_a[i], exp_a[i], beats[i]);
            end
        end
        n_chk++;
        if (done_ok !== 1'b1 || done_loaded !== 10'd4) begin
            n_fail++; $display("FAIL wrap_result: got ok=%b loaded=%0d expected 1 4", done_ok, done_loaded);
        end
    endtask

    task automatic test_last();
        beats = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h00, 8'h00, 8'h00};
        run_load(9'h080, 10'd8, 6, 1'b0, 5, 2);
        n_chk++;
        if (n_xfer !== 3 || wlog_a.size() - s_w !== 3) begin
            n_fail++; $display("FAIL last_writes: got xfer=%0d writes=%0d expected 3 3", n_xfer, wlog_a.size() - s_w);
        end
        n_chk++;
        if (rdy_cnt - s_rdy !== 3) begin
            n_fail++; $display("FAIL last_ready_cycles: got %0d expected 3", rdy_cnt - s_rdy);
        end
        n_chk++;
        if (rlog_a.size() - s_r !== 3 || done_cyc - t0 + 1 !== 8) begin
            n_fail++; $display("FAIL last_verify: got reads=%0d latency=%0d expected 3 8", rlog_a.size() - s_r, done_cyc - t0 + 1);
        end
        n_chk++;
        if (done_ok !== 1'b1 || done_loaded !== 10'd3) begin
            n_fail++; $display("FAIL last_result: got ok=%b loaded=%0d expected 1 3", done_ok, done_loaded);
        end
    endtask

    task automatic test_corrupt();
        beats   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        corrupt = 1'b1;
        run_load(9'h010, 10'd4, 4, 1'b0, 4, -1);
        corrupt = 1'b0;
        n_chk++;
        if (done_cnt - s_done !== 1 || done_ok !== 1'b0 || done_loaded !== 10'd4) begin
            n_fail++;
            $display("FAIL corrupt_result: got pulses=%0d ok=%b loaded=%0d expected 1 0 4", done_cnt - s_done, done_ok, done_loaded);
        end
    endtask

    task automatic test_zero_count();
        run_load(9'h100, 10'd0, 0, 1'b0, 0, -1);
        n_chk++;
        if (done_cnt - s_done !== 1 || done_cyc - t0 + 1 !== 2) begin
            n_fail++; $display("FAIL zero_latency: got pulses=%0d latency=%0d expected 1 2", done_cnt - s_done, done_cyc - t0 + 1);
        end
        n_chk++;
        if (wlog_a.size() - s_w !== 0 || rlog_a.size() - s_r !== 0) begin
            n_fail++; $display("FAIL zero_ram_access: got w=%0d r=%0d expected 0 0", wlog_a.size() - s_w, rlog_a.size() - s_r);
        end
        n_chk++;
        if (done_ok !== 1'b1 || done_loaded !== 10'd0 || busy_cnt - s_busy !== 2) begin
            n_fail++;
            $display("FAIL zero_result: got ok=%b loaded=%0d busy=%0d expected 1 0 2", done_ok, done_loaded, busy_cnt - s_busy);
        end
    endtask

    task automatic test_start_while_busy();
        beats = '{8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_start(9'h050, 10'd2);
        in_valid = 1'b1;
        in_data  = beats[0];
        @(posedge clk);
        #1;
        in_data = beats[1];
        start   = 1'b1;
        base    = 9'h060;
        count   = 10'd5;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        wait_done();
        repeat (10) @(posedge clk);
        #1;
        n_chk++;
        if (done_cnt - s_done !== 1 || busy_cnt - s_busy !== 6) begin
            n_fail++; $display("FAIL busy_start_ignored: got pulses=%0d busy=%0d expected 1 6", done_cnt - s_done, busy_cnt - s_busy);
        end
        n_chk++;
        if (wlog_a.size() - s_w !== 2 || wlog_a[s_w] !== 9'h050 || wlog_a[s_w + 1] !== 9'h051) begin
            n_fail++; $display("FAIL busy_writes: got n=%0d a0=%h a1=%h expected 2 050 051", wlog_a.size() - s_w, wlog_a[s_w], wlog_a[s_w + 1]);
        end
        n_chk++;
        if (done_ok !== 1'b1 || done_loaded !== 10'd2) begin
            n_fail++; $display("FAIL busy_result: got ok=%b loaded=%0d expected 1 2", done_ok, done_loaded);
        end
    endtask

    task automatic test_reset_mid();
        beats = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h00, 8'h00, 8'h00, 8'h00};
        do_start(9'h030, 10'd4);
        in_valid = 1'b1;
        in_data  = beats[0];
        @(posedge clk);
        #1;
        in_data = beats[1];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        resetn   = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({ram_wen, ram_ren, busy, in_ready, done} !== 5'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b expected 00000", {ram_wen, ram_ren, busy, in_ready, done});
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (wlog_a.size() - s_w !== 2 || in_ready !== 1'b0 || loaded !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_idle: got writes=%0d in_ready=%b loaded=%0d expected 2 0 0", wlog_a.size() - s_w, in_ready, loaded);
        end
        beats = '{8'hE1, 8'hE2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load(9'h040, 10'd2, 2, 1'b0, 2, -1);
        n_chk++;
        if (wlog_a.size() - s_w !== 2 || wlog_a[s_w] !== 9'h040 || wlog_a[s_w + 1] !== 9'h041) begin
            n_fail++; $display("FAIL midreset_reload: got n=%0d a0=%h a1=%h expected 2 040 041", wlog_a.size() - s_w, wlog_a[s_w], wlog_a[s_w + 1]);
        end
        n_chk++;
        if (done_ok !== 1'b1 || done_loaded !== 10'd2 || done_cnt - s_done !== 1) begin
            n_fail++; $display("FAIL midreset_result: got ok=%b loaded=%0d pulses=%0d expected 1 2 1", done_ok, done_loaded, done_cnt - s_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_wrap();
        test_last();
        test_corrupt();
        test_zero_count();
        test_start_while_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Stream-to-RAM loader that sits directly upstream of one port of the dual-ported synchronous RAM.
- Accepts a valid/ready byte stream and writes it to consecutive RAM addresses.
- Reads the written region back and compares a modular checksum of the written data against the read data.
- Used to preload program/data memory before the processor leaves reset, and as a built-in memory self-check.

Parameters:
wordsize, 8, bits per RAM word and per stream beat
wordcount, 512, number of RAM words; address arithmetic wraps modulo wordcount
addrsize, 9, RAM address width; must be >= log2(wordcount)

Ports:
clock  in  1  system clock; all loader state on rising edge
resetn  in  1  synchronous active-low reset, sampled on rising edge of clock
start  in  1  pulse: begin a load; ignored unless busy=0
base  in  addrsize  first RAM address, sampled when start accepted
count  in  addrsize+1  words to load, sampled when start accepted
in_valid  in  1  stream beat valid
in_data  in  wordsize  stream beat data
in_last  in  1  final beat marker, qualified by in_valid
in_ready  out  1  loader accepts a beat this cycle
ram_addr  out  addrsize  to RAM port addr
ram_wen  out  1  to RAM port write enable
ram_wdat  out  wordsize  to RAM port write data
ram_ren  out  1  to RAM port read enable
ram_rdat  in  wordsize  from RAM port read data (RAM updates it on falling edge)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of operation
ok  out  1  checksum match; valid when done=1, held until next start
loaded  out  addrsize+1  number of words written; valid when done=1, held

Behaviour:
- Reset values: state IDLE, in_ready=0, ram_wen=0, ram_ren=0, ram_addr=0, ram_wdat=0, busy=0, done=0, ok=0, loaded=0.
- Reset has priority over every other event, including mid-LOAD and mid-VERIFY. ram_wen and ram_ren are low in the cycle after the reset edge, so no RAM write occurs in that cycle.
- All RAM-side outputs are registered on the rising edge, so they are stable before the RAM's falling-edge access in the same cycle.
- States: IDLE, LOAD, VERIFY, FIN.
- IDLE:
  - start=1 captures base and a remaining counter rem = min(count, wordcount).
  - Clears both sums and loaded; sets busy=1.
  - Goes to LOAD, or to FIN if rem=0.
- LOAD:
  - in_ready = (state==LOAD) && (rem!=0); combinational from state only, never from in_valid.
  - Beat transfers when in_valid && in_ready at a rising edge.
  - On a transfer: next cycle ram_wen=1, ram_addr=wptr, ram_wdat=in_data (write lands on that cycle's falling edge). Also wptr=(wptr+1) mod wordcount, rem-1, loaded+1, wsum=(wsum+in_data) mod 2^wordsize.
  - No transfer in a cycle means ram_wen=0 the next cycle.
  - Leave LOAD when a beat transfers with in_last=1, or when rem reaches 0.
  - Stream beats arriving after LOAD ends are not accepted (in_ready=0).
- VERIFY:
  - Re-reads loaded words starting at base.
  - First VERIFY cycle has ram_ren=1, ram_addr=base; the address increments modulo wordcount each cycle while reads remain.
  - Read latency: data for the address driven in cycle N is sampled from ram_rdat at the rising edge ending cycle N. The RAM captures it on the falling edge inside N.
  - At each such edge: rsum=(rsum+ram_rdat) mod 2^wordsize.
  - VERIFY lasts exactly loaded cycles; ram_ren=0 on exit.
  - The final write (last LOAD write cycle) precedes the first read by at least one cycle, so there is no read/write same-address hazard.
- FIN: one cycle with done=1, ok=(wsum==rsum), busy=0 on the following cycle; returns to IDLE.
  - If loaded=0: ok=1 and no RAM access occurs.
- start while busy=1 is ignored.
- Address wrap: base+i beyond wordcount-1 continues at 0.
- Total latency from start accepted to done: 1 + (LOAD cycles) + loaded + 1.

Test Plan:
- base=0x010, count=4, beats 0x11,0x22,0x33,0x44 with in_valid continuously high -> RAM[0x10..0x13] written in order; VERIFY 4 cycles; done with ok=1, loaded=4; busy high 10 cycles total.
- Same load with in_valid low on alternate cycles -> ram_wen only in cycles after transfers; identical RAM contents; ok=1.
- base=0x1FE, count=4 (wordcount=512) -> writes to 0x1FE,0x1FF,0x000,0x001; readback addresses follow the same wrap; ok=1.
- count=8, in_last on beat 3 -> exactly 3 writes, in_ready=0 afterwards; loaded=3; VERIFY 3 cycles; ok=1.
- Bench corrupts RAM[0x12] (forces ram_rdat 0x00 in place of 0x33 on that read) -> done with ok=0.
- Reset: resetn=0 mid-LOAD after 2 beats -> next cycle ram_wen=0, busy=0, in_ready=0, state IDLE. start again -> fresh load from new base. count=0 -> done next-but-one cycle, ok=1, no ram_wen/ram_ren. start while busy -> ignored.
